// File: rtl/spi_slave_param_pkg.sv
// spi_pkg: FSM state encoding and command codes for the SPI slave.
// Shared by the interface, the top and the MISO shifter.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_param_if.sv
// spi_slave_param_if: serial pins plus rx/tx word handshake.
// frame_err exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_param_if
   import spi_pkg::*;
#(
   parameter int CMD_W  = 2,
   parameter int DATA_W = 8
);

   logic                    SS_n;
   logic                    MOSI;
   logic                    MISO;
   logic [CMD_W+DATA_W-1:0] rx_data;
   logic                    rx_valid;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic                    frame_err;

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid, frame_err
   );

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid, frame_err
   );
`else
   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );
`endif

endinterface

// File: rtl/spi_slave_param_tx_shifter.sv
// spi_tx_shifter: loads a read-data word and shifts it out MSB first.
// done is high on the edge that retires the last bit.
module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              miso,
   output logic              busy,
   output logic              done
);

   localparam int BW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sh;
   logic [BW-1:0]     bcnt;

   assign done = busy && (bcnt == BW'(DATA_W));

   // MSB is presented on the load edge, one further bit per clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh   <= '0;
         bcnt <= '0;
         busy <= 1'b0;
         miso <= 1'b0;
      end else if (clr) begin
         bcnt <= '0;
         busy <= 1'b0;
         miso <= 1'b0;
      end else if (load) begin
         sh   <= din << 1;
         miso <= din[DATA_W-1];
         bcnt <= BW'(1);
         busy <= 1'b1;
      end else if (busy) begin
         if (done) begin
            miso <= 1'b0;
            busy <= 1'b0;
         end else begin
            miso <= sh[DATA_W-1];
            sh   <= sh << 1;
            bcnt <= bcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: one CMD_W+DATA_W frame per SS_n-low window.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err truncation pulse.
module spi_slave_param
   import spi_pkg::*;
#(
   parameter int CMD_W  = 2,
   parameter int DATA_W = 8
) (
   input logic                clk,
   input logic                rst,
   spi_slave_param_if.slave   bus
);

   localparam int FRAME_W = CMD_W + DATA_W;
   localparam int CW      = $clog2(FRAME_W + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_W);

   state_t             state;
   state_t             state_nx;
   logic [FRAME_W-1:0] sh;
   logic [FRAME_W-1:0] rx_q;
   logic               rxv_q;
   logic [CW-1:0]      cnt;
   logic               got;
   logic               sent;
   logic               rd_addr_seen;
   logic               rx_phase;
   logic               take;
   logic               fin;
   logic               load;
   logic               tx_busy;
   logic               tx_done;
   logic               tx_miso;

   assign rx_phase = (state != IDLE);
   assign take = !bus.SS_n && rx_phase && (cnt != CNT_MAX);
   assign fin  = !bus.SS_n && rx_phase && (cnt == CNT_MAX) && !got;
   assign load = !bus.SS_n && (state == READ_DATA) && got
               && !sent && !tx_busy && bus.tx_valid;

   assign bus.rx_data  = rx_q;
   assign bus.rx_valid = rxv_q;
   assign bus.MISO     = tx_miso;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // routing: first sampled bit plus the registered read-address flag
   always_comb begin
      state_nx = state;
      if (bus.SS_n) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nx = CHK_CMD;
            CHK_CMD: state_nx = !bus.MOSI ? WRITE
                              : (rd_addr_seen ? READ_DATA : READ_ADD);
            default: state_nx = state;
         endcase
      end
   end

   // receive shifter, frame delivery and read-address tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh           <= '0;
         rx_q         <= '0;
         rxv_q        <= 1'b0;
         cnt          <= '0;
         got          <= 1'b0;
         sent         <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         rxv_q <= 1'b0;
         if (bus.SS_n) begin
            cnt  <= '0;
            got  <= 1'b0;
            sent <= 1'b0;
         end else begin
            if (take) begin
               sh  <= {sh[FRAME_W-2:0], bus.MOSI};
               cnt <= cnt + 1'b1;
            end
            if (fin) begin
               rx_q  <= sh;
               rxv_q <= 1'b1;
               got   <= 1'b1;
               if (state == READ_ADD) rd_addr_seen <= 1'b1;
            end
            if (load)    sent         <= 1'b1;
            if (tx_done) rd_addr_seen <= 1'b0;
         end
      end
   end

   spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.SS_n),
      .load (load),
      .din  (bus.tx_data),
      .miso (tx_miso),
      .busy (tx_busy),
      .done (tx_done)
   );

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic ferr;

   // pulse when SS_n ends a partial frame or an unfinished MISO word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ferr <= 1'b0;
      else     ferr <= bus.SS_n
                     && ((rx_phase && cnt != '0 && cnt != CNT_MAX)
                         || tx_busy);
   end

   assign bus.frame_err = ferr;
`endif

endmodule
